// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, bit-period helper and transmitter state type
package uart_pkg;
    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD = 115200;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte request/status handshake and serial line of the UART transmitter
interface uart_tx_if;
    logic [7:0] tx_data;
    logic tx_send;
    logic tx_busy;
    logic tx_done;
    logic tx;
    modport master (output tx_data, tx_send, input tx_busy, tx_done, tx);
    modport slave (input tx_data, tx_send, output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer, ticks for one cycle at count BIT_CYCLES-1
module uart_baud_tick #(
    parameter int BIT_CYCLES = 868
) (
    input  logic clock,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(BIT_CYCLES);
    logic [W-1:0] count;
    assign tick = enable && count == W'(BIT_CYCLES - 1);
    // count while enabled, wrap on each bit boundary, clear on new frame or reset
    always_ff @(posedge clock) begin
        if (clear) count <= '0;
        else if (enable) count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with registered line output
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD = DEF_BAUD
) (
    input logic clock,
    input logic reset,
    uart_tx_if.slave bus
);
    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    if (BIT_CYCLES < 2) begin : g_bit_cycles_check
        $error("uart_tx: BIT_CYCLES must be at least 2");
    end
    tx_state_t state, next_state;
    logic [7:0] shreg, shreg_d;
    logic [2:0] idx;
    logic tick, accept, tx_d, done_d, tx_q, done_q;
    assign accept = state == IDLE && bus.tx_send;
    uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
        .clock (clock),
        .enable(state != IDLE),
        .clear (reset || accept),
        .tick  (tick)
    );
    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end
    // next state: each phase lasts whole bit periods, DATA lasts eight of them
    always_comb begin
        next_state = state == IDLE  ? (bus.tx_send ? START : IDLE) :
                     state == START ? (tick ? DATA : START) :
                     state == DATA  ? (tick && idx == 3'd7 ? STOP : DATA) :
                                      (tick ? IDLE : STOP);
    end
    // outputs: line level is computed for the next state so it can be registered
    always_comb begin
        shreg_d = accept ? bus.tx_data : (state == DATA && tick) ? {1'b0, shreg[7:1]} : shreg;
        tx_d = next_state == DATA ? shreg_d[0] : next_state != START;
        done_d = state == STOP && tick;
    end
    // datapath registers: shift register, bit index, glitch-free line and done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
            idx <= '0;
            tx_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            shreg <= shreg_d;
            idx <= accept ? 3'd0 : (state == DATA && tick) ? idx + 3'd1 : idx;
            tx_q <= tx_d;
            done_q <= done_d;
        end
    end
    assign bus.tx = tx_q;
    assign bus.tx_busy = state != IDLE;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table-driven bench for uart_tx at 16 cycles per bit
module tb_uart_tx;
    localparam int BC = 16;
    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    uart_tx_if bus ();
    uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        int         poke;
        logic [7:0] alt;
    } vec_t;
    vec_t vecs[6];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk1("idle_tx", bus.tx, 1'b1);
            chk1("idle_busy", bus.tx_busy, 1'b0);
            chk1("idle_done", bus.tx_done, 1'b0);
            step();
        end
    endtask

    // entered in cycle N+1; leaves the bench in cycle N+161 (the done cycle)
    task automatic check_frame(input logic [7:0] exp, input int poke, input logic [7:0] alt);
        logic [9:0] frame;
        logic [7:0] rx;
        frame = {1'b1, exp, 1'b0};
        rx = '0;
        for (int i = 0; i < 10 * BC; i++) begin
            chk1("frame_tx", bus.tx, frame[i / BC]);
            chk1("frame_busy", bus.tx_busy, 1'b1);
            chk1("frame_done_early", bus.tx_done, 1'b0);
            if (i % BC == BC / 2 && i / BC >= 1 && i / BC <= 8) rx[i / BC - 1] = bus.tx;
            if (i + 1 == poke) begin
                bus.tx_send = 1'b1;
                bus.tx_data = alt;
            end else if (i == poke) bus.tx_send = 1'b0;
            step();
        end
        chk8("rx_data", rx, exp);
        chk1("done_pulse", bus.tx_done, 1'b1);
        chk1("done_busy", bus.tx_busy, 1'b0);
        chk1("done_tx", bus.tx, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, -1, 8'h00};
        vecs[1] = '{8'hA5, 40, 8'hFF};
        vecs[2] = '{8'h00, -1, 8'h00};
        vecs[3] = '{8'h55, -1, 8'h00};
        vecs[4] = '{8'hAA, -1, 8'h00};
        vecs[5] = '{8'hFF, -1, 8'h00};
        reset = 1'b1;
        bus.tx_send = 1'b0;
        bus.tx_data = 8'h00;
        step();
        step();
        reset = 1'b0;
        check_idle(20);
        for (int v = 0; v < 6; v++) begin
            bus.tx_data = vecs[v].data;
            bus.tx_send = 1'b1;
            step();
            bus.tx_send = 1'b0;
            check_frame(vecs[v].data, vecs[v].poke, vecs[v].alt);
            step();
            check_idle(20);
        end
        bus.tx_data = 8'h00;
        bus.tx_send = 1'b1;
        step();
        check_frame(8'h00, -1, 8'h00);
        bus.tx_data = 8'hFF;
        step();
        check_frame(8'hFF, -1, 8'h00);
        bus.tx_send = 1'b0;
        step();
        check_idle(20);
        bus.tx_data = 8'h00;
        bus.tx_send = 1'b1;
        step();
        bus.tx_send = 1'b0;
        repeat (49) step();
        chk1("pre_reset_tx", bus.tx, 1'b0);
        chk1("pre_reset_busy", bus.tx_busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle(200);
        bus.tx_data = 8'h3C;
        bus.tx_send = 1'b1;
        step();
        bus.tx_send = 1'b0;
        check_frame(8'h3C, -1, 8'h00);
        step();
        check_idle(5);
        bus.tx_send = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.tx_send = 1'b0;
        check_idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
